// File: rtl/div_sched_pkg.sv
// Shared types and the round-robin picker for the divided-clock scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    // First set bit of req_v searching upward from last+1 with wrap over n entries.
    // Returns last when nothing is set; callers gate on |req.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req_v,
                                            input int unsigned       last,
                                            input int unsigned       n);
        int unsigned idx;
        rr_pick = last;
        for (int unsigned i = MAX_REQ; i >= 1; i--) begin
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req_v[idx[IDX_W-1:0]]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/divided_clock_scheduler_sclk_gen.sv
// Programmable half-period divider; parked at the idle level with a cleared counter while run is low.
module sclk_gen #(
    parameter int   DIV_W      = 16,
    parameter logic IDLE_STATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             div_clk_out,
    output logic             edge_stb,
    output logic             period_stb
);

    logic [DIV_W-1:0] half_cnt;
    logic             toggle;

    assign toggle = run && (half_cnt == div - DIV_W'(1));
    // Flags the toggle that brings the output back to idle, i.e. a full period ends at this edge.
    assign period_stb = toggle && (div_clk_out != IDLE_STATE);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            half_cnt    <= '0;
            div_clk_out <= IDLE_STATE;
            edge_stb    <= 1'b0;
        end else begin
            edge_stb <= toggle;
            if (toggle) begin
                half_cnt    <= '0;
                div_clk_out <= ~div_clk_out;
            end else begin
                half_cnt <= half_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/divided_clock_scheduler.sv
// Round-robin scheduler that lends one divided-clock generator to NUM_REQ requesters for fixed-length bursts.
module divided_clock_scheduler
    import div_sched_pkg::*;
#(
    parameter int   NUM_REQ    = 4,
    parameter int   DIV_W      = 16,
    parameter int   CNT_W      = 8,
    parameter logic IDLE_STATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DIV_W-1:0] req_div,
    input  logic [NUM_REQ*CNT_W-1:0] req_cycles,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     div_clk_out,
    output logic                     edge_stb
);

    // Handshake: req is a level request sampled only in IDLE; grant stays high for the whole
    // burst, done pulses once to the owner as grant falls, and the owner must drop req by the
    // cycle after done or it competes again.

    localparam int OWN_W = $clog2(NUM_REQ);

    sched_state_e       state, next_state;
    logic [OWN_W-1:0]   last_grant, pick;
    logic [DIV_W-1:0]   div_l, pick_div;
    logic [CNT_W-1:0]   cycles_l, pick_cycles, period_cnt;
    logic [NUM_REQ-1:0] grant_d, done_d;
    logic               load, finish, gen_run, period_stb;

    always_comb begin
        pick        = OWN_W'(rr_pick(MAX_REQ'(req), 32'(last_grant), unsigned'(NUM_REQ)));
        pick_div    = req_div[int'(pick)*DIV_W +: DIV_W];
        pick_cycles = req_cycles[int'(pick)*CNT_W +: CNT_W];
    end

    // A zero-length burst finishes on its first RUN cycle without ever starting the generator.
    assign gen_run = (state == RUN) && (cycles_l != '0);
    assign finish  = (cycles_l == '0) ||
                     (period_stb && (period_cnt == cycles_l - CNT_W'(1)));

    always_comb begin
        next_state = state;
        grant_d    = grant;
        done_d     = '0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                grant_d = '0;
                if (|req) begin
                    next_state = RUN;
                    load       = 1'b1;
                    grant_d    = NUM_REQ'(1) << pick;
                end
            end
            RUN: begin
                if (finish) begin
                    next_state = GAP;
                    grant_d    = '0;
                    done_d     = NUM_REQ'(1) << last_grant;
                end
            end
            GAP: begin
                grant_d    = '0;
                next_state = IDLE;
            end
            default: begin
                grant_d    = '0;
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            last_grant <= OWN_W'(NUM_REQ - 1);
            div_l      <= DIV_W'(1);
            cycles_l   <= '0;
            period_cnt <= '0;
        end else begin
            state <= next_state;
            grant <= grant_d;
            done  <= done_d;
            busy  <= (next_state != IDLE);
            if (load) begin
                last_grant <= pick;
                div_l      <= (pick_div == '0) ? DIV_W'(1) : pick_div;
                cycles_l   <= pick_cycles;
                period_cnt <= '0;
            end else if ((state == RUN) && period_stb) begin
                period_cnt <= period_cnt + CNT_W'(1);
            end
        end
    end

    sclk_gen #(
        .DIV_W      (DIV_W),
        .IDLE_STATE (IDLE_STATE)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .run         (gen_run),
        .div         (div_l),
        .div_clk_out (div_clk_out),
        .edge_stb    (edge_stb),
        .period_stb  (period_stb)
    );

endmodule
